mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle control unit for the 16-bit datapath. It sits directly upstream of the 16x16 register file.
- Fetches instructions from a synchronous-read memory and decodes them.
- Drives the register file's one-hot write enables and read addresses, the ALU op, and the memory address/write strobe. The write-back mux select chooses between the ALU result and memory read data.
- One instruction completes every 4 cycles (LOAD takes 6).

Parameters:
- PC_RESET, 16'h0000, value loaded into pc on reset.
- STATUS_REG, 4, 15, index of the hardware-driven read-only register; its write enable is always masked to 0.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; dominates every other input
- run  input  1  1 = execute; 0 = hold in S_FETCH before issuing the next fetch
- mem_rdata  input  16  memory read data, valid one cycle after the address is presented
- rdata_a  input  16  register file port A data (Rdest)
- rdata_b  input  16  register file port B data (Rsrc)
- pc  output  16  program counter
- mem_addr  output  16  memory address
- mem_we  output  1  memory write strobe, single-cycle
- mem_wdata  output  16  store data (= rdata_a)
- reg_enable  output  16  one-hot register write enable
- raddr_a  output  4  = ir[11:8] (Rdest)
- raddr_b  output  4  = ir[3:0] (Rsrc)
- alu_op  output  4  ALU operation select
- alu_b_imm  output  1  1 = ALU B operand is imm16
- imm16  output  16  sign-extended ir[7:0]
- wb_sel  output  1  0 = ALU result to register file, 1 = mem_rdata
- ir  output  16  instruction register
- state_dbg  output  3  current state encoding

Behaviour:
- Reset values:
  - pc = PC_RESET, ir = 0, state = S_FETCH.
  - reg_enable = 0, mem_we = 0, wb_sel = 0, alu_op = 0, alu_b_imm = 0, mem_addr = PC_RESET.
- Reset asserted in any state aborts the instruction. No reg_enable or mem_we pulse may occur in a cycle where reset = 1.
- State encodings: S_FETCH=0, S_FWAIT=1, S_DECODE=2, S_EXEC=3, S_LWAIT=4, S_LWB=5.
- S_FETCH:
  - mem_addr = pc.
  - If run = 1, go to S_FWAIT; otherwise stay in S_FETCH.
- S_FWAIT:
  - mem_addr = pc.
  - At the clock edge, ir <= mem_rdata; go to S_DECODE.
- S_DECODE:
  - raddr_a/raddr_b settle from ir; go to S_EXEC.
  - No side effects.
- Decode of ir[15:12]:
  - 4'b0000: R-type. alu_op = ir[7:4], alu_b_imm = 0.
  - 4'b0001 to 4'b1011, excluding 4'b0100: immediate. alu_op = ir[15:12], alu_b_imm = 1.
  - 4'b0100 with ir[7:4] = 0000: LOAD, Rdest <= mem[Rsrc].
  - 4'b0100 with ir[7:4] = 0100: STOR, mem[Rsrc] <= Rdest.
  - 4'b0100 with any other ir[7:4]: NOP.
  - 4'b1100 to 4'b1111: NOP (reserved).
- S_EXEC:
  - R-type/immediate: reg_enable = one-hot(ir[11:8]) for this cycle only, wb_sel = 0, pc <= pc+1, then S_FETCH.
  - STOR: mem_addr = rdata_b, mem_wdata = rdata_a, mem_we = 1 for this cycle, pc <= pc+1, then S_FETCH.
  - LOAD: mar <= rdata_b; mem_addr = rdata_b; go to S_LWAIT.
  - NOP: pc <= pc+1, then S_FETCH. No enables.
- S_LWAIT: mem_addr = mar; go to S_LWB.
- S_LWB: wb_sel = 1, reg_enable = one-hot(ir[11:8]), pc <= pc+1, then S_FETCH.
- Status register masking:
  - reg_enable[STATUS_REG] is forced to 0 in every state.
  - A write targeting STATUS_REG completes with no enable asserted, and pc still advances.
- At most one reg_enable bit is high in any cycle. reg_enable and mem_we are never high in the same cycle.
- pc arithmetic is 16-bit modulo: 16'hFFFF + 1 = 16'h0000.
- run deasserted mid-instruction does not stall. The current instruction completes; the hold takes effect at the next S_FETCH.
- imm16 = {{8{ir[7]}}, ir[7:0]}.
- Cycle counts, measured from S_FETCH with run = 1:
  - ALU/STOR/NOP: 4 cycles.
  - LOAD: 6 cycles.

Test Plan:
- Reset then run=1, mem returns 16'h0312 at addr 0 (R-type, Rdest=3, op=1, Rsrc=2):
  - raddr_a=3, raddr_b=2, alu_op=1, alu_b_imm=0.
  - reg_enable=16'h0008 for exactly one cycle on cycle 4.
  - pc becomes 1.
- Immediate 16'h52F0:
  - imm16=16'hFFF0, alu_b_imm=1, alu_op=5.
  - reg_enable=16'h0004 once; 4-cycle period.
- LOAD 16'h4106 with rdata_b=16'h0040:
  - mem_addr=16'h0040 in S_EXEC and S_LWAIT.
  - wb_sel=1 and reg_enable=16'h0002 in cycle 6; pc+1.
- STOR 16'h4347 with rdata_a=16'hBEEF, rdata_b=16'h0080:
  - mem_we=1, mem_addr=16'h0080, mem_wdata=16'hBEEF for one cycle.
  - reg_enable stays 0 throughout.
- Corner cases:
  - ALU write to Rdest=15: no reg_enable bit set.
  - Opcode 4'b1110: no enables, pc+1.
  - pc preset to 16'hFFFF wraps to 16'h0000.
- Control timing:
  - reset asserted in S_LWB: no reg_enable pulse; next cycle pc=0 and state=S_FETCH.
  - run=0 holds in S_FETCH indefinitely with mem_addr=pc.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the 16-bit datapath.
// Fetches from a synchronous-read memory, decodes, and drives register-file
// write enables, ALU controls and the memory address/write strobe.
// ALU, STOR and NOP instructions take 4 cycles. LOAD takes 6 cycles.
module mc_control_fsm #(
    parameter logic [15:0] PC_RESET   = 16'h0000,
    parameter logic [3:0]  STATUS_REG = 4'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] rdata_a,
    input  logic [15:0] rdata_b,
    output logic [15:0] pc,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    output logic [15:0] reg_enable,
    output logic [3:0]  raddr_a,
    output logic [3:0]  raddr_b,
    output logic [3:0]  alu_op,
    output logic        alu_b_imm,
    output logic [15:0] imm16,
    output logic        wb_sel,
    output logic [15:0] ir,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_LWAIT  = 3'd4,
        S_LWB    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        K_ALU,
        K_LOAD,
        K_STOR,
        K_NOP
    } kind_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mar_q, mar_d;
    kind_t       kind;
    logic [15:0] dest_onehot;

    // Classify the held instruction by its opcode and sub-opcode.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default first, so no path infers a latch.
        kind = K_NOP;
        case (ir_q[15:12])
            4'h0:                   kind = K_ALU;
            4'h4: begin
                if (ir_q[7:4] == 4'h0)      kind = K_LOAD;
                else if (ir_q[7:4] == 4'h4) kind = K_STOR;
                else                        kind = K_NOP;
            end
            4'hC, 4'hD, 4'hE, 4'hF: kind = K_NOP;
            default:                kind = K_ALU;
        endcase
    end

    // The status register is written by hardware only, so its enable bit is always cleared.
    assign dest_onehot = (16'h0001 << ir_q[11:8]) & ~(16'h0001 << STATUS_REG);

    // Compute the next state, next pc, instruction register and load address register.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mar_d   = mar_q;
        case (state_q)
            S_FETCH:  if (run) state_d = S_FWAIT;
            S_FWAIT: begin
                ir_d    = mem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (kind == K_LOAD) begin
                    mar_d   = rdata_b;
                    state_d = S_LWAIT;
                end else begin
                    pc_d    = pc_q + 16'd1;
                    state_d = S_FETCH;
                end
            end
            S_LWAIT:  state_d = S_LWB;
            S_LWB: begin
                pc_d    = pc_q + 16'd1;
                state_d = S_FETCH;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // Register the state. Reset takes priority over every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            mar_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
        end
    end

    // Decode the strobes and the memory address from the current state.
    // Forcing them while reset is high suppresses any write pulse in the cycle of an abort.
    always_comb begin
        mem_addr   = pc_q;
        mem_we     = 1'b0;
        reg_enable = '0;
        wb_sel     = 1'b0;
        alu_op     = (ir_q[15:12] == 4'h0) ? ir_q[7:4] : ir_q[15:12];
        alu_b_imm  = (kind == K_ALU) && (ir_q[15:12] != 4'h0);
        case (state_q)
            S_EXEC: begin
                case (kind)
                    K_ALU:  reg_enable = dest_onehot;
                    K_STOR: begin
                        mem_addr = rdata_b;
                        mem_we   = 1'b1;
                    end
                    K_LOAD: mem_addr = rdata_b;
                    default: ;
                endcase
            end
            S_LWAIT: mem_addr = mar_q;
            S_LWB: begin
                wb_sel     = 1'b1;
                reg_enable = dest_onehot;
            end
            default: ;
        endcase
        if (reset) begin
            mem_addr   = PC_RESET;
            mem_we     = 1'b0;
            reg_enable = '0;
            wb_sel     = 1'b0;
            alu_op     = '0;
            alu_b_imm  = 1'b0;
        end
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign raddr_a   = ir_q[11:8];
    assign raddr_b   = ir_q[3:0];
    assign imm16     = {{8{ir_q[7]}}, ir_q[7:0]};
    assign mem_wdata = rdata_a;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm. It uses an instruction-level reference model and randomized instruction streams.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        reset, run, run_w;
    logic [15:0] mem_rdata, rdata_a, rdata_b;
    logic [15:0] pc, mem_addr, mem_wdata, reg_enable, imm16, ir;
    logic        mem_we, alu_b_imm, wb_sel;
    logic [3:0]  raddr_a, raddr_b, alu_op;
    logic [2:0]  state_dbg;

    // The second instance has its pc preset to 16'hFFFF, which is used to test the pc wrap.
    logic [15:0] w_mem_rdata, w_pc, w_mem_addr, w_mem_wdata, w_reg_enable, w_imm16, w_ir;
    logic        w_mem_we, w_alu_b_imm, w_wb_sel;
    logic [3:0]  w_raddr_a, w_raddr_b, w_alu_op;
    logic [2:0]  w_state_dbg;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_pc;
    logic [15:0] mem [256];

    typedef enum {K_ALU, K_LOAD, K_STOR, K_NOP} kind_e;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .pc(pc), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .reg_enable(reg_enable),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .alu_op(alu_op),
        .alu_b_imm(alu_b_imm), .imm16(imm16), .wb_sel(wb_sel), .ir(ir),
        .state_dbg(state_dbg)
    );

    mc_control_fsm #(.PC_RESET(16'hFFFF)) dut_w (
        .clk(clk), .reset(reset), .run(run_w), .mem_rdata(w_mem_rdata),
        .rdata_a(16'h0000), .rdata_b(16'h0000), .pc(w_pc), .mem_addr(w_mem_addr),
        .mem_we(w_mem_we), .mem_wdata(w_mem_wdata), .reg_enable(w_reg_enable),
        .raddr_a(w_raddr_a), .raddr_b(w_raddr_b), .alu_op(w_alu_op),
        .alu_b_imm(w_alu_b_imm), .imm16(w_imm16), .wb_sel(w_wb_sel), .ir(w_ir),
        .state_dbg(w_state_dbg)
    );

    // Synchronous-read memory. The read data is valid one cycle after the address.
    always @(posedge clk) mem_rdata <= mem[mem_addr[7:0]];

    function automatic kind_e classify(input logic [15:0] i);
        logic [3:0] opc = i[15:12];
        if (opc == 4'h0) return K_ALU;
        if (opc == 4'h4) begin
            if (i[7:4] == 4'h0) return K_LOAD;
            if (i[7:4] == 4'h4) return K_STOR;
            return K_NOP;
        end
        if (opc <= 4'd11) return K_ALU;
        return K_NOP;
    endfunction

    // Run one instruction from S_FETCH and check each of its cycles against the model.
    task automatic run_instr(input logic [15:0] instr, input logic [15:0] ra, input logic [15:0] rb);
        kind_e       k   = classify(instr);
        int          len = (k == K_LOAD) ? 6 : 4;
        logic [15:0] wen = (instr[11:8] == 4'd15) ? 16'h0000 : (16'h0001 << instr[11:8]);
        logic [15:0] exp_en, exp_addr;
        logic [3:0]  exp_op;
        logic        exp_we;
        mem[exp_pc[7:0]] = instr;
        rdata_a = ra;
        rdata_b = rb;
        run     = 1'b1;
        exp_op  = (instr[15:12] == 4'h0) ? instr[7:4] : instr[15:12];
        for (int c = 1; c <= len; c++) begin
            n_tests++;
            if (state_dbg !== 3'(c - 1)) begin
                n_fail++;
                $display("FAIL state instr=%h c=%0d got %0d exp %0d", instr, c, state_dbg, c - 1);
            end
            n_tests++;
            if (pc !== exp_pc) begin
                n_fail++;
                $display("FAIL pc_hold instr=%h c=%0d got %h exp %h", instr, c, pc, exp_pc);
            end
            exp_en = ((k == K_ALU && c == 4) || (k == K_LOAD && c == 6)) ? wen : 16'h0000;
            n_tests++;
            if (reg_enable !== exp_en) begin
                n_fail++;
                $display("FAIL reg_enable instr=%h c=%0d got %h exp %h", instr, c, reg_enable, exp_en);
            end
            exp_we = (k == K_STOR && c == 4);
            n_tests++;
            if (mem_we !== exp_we) begin
                n_fail++;
                $display("FAIL mem_we instr=%h c=%0d got %b exp %b", instr, c, mem_we, exp_we);
            end
            if (c <= 2 || c == 5 || (c == 4 && (k == K_LOAD || k == K_STOR))) begin
                exp_addr = (c <= 2) ? exp_pc : rb;
                n_tests++;
                if (mem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL mem_addr instr=%h c=%0d got %h exp %h", instr, c, mem_addr, exp_addr);
                end
            end
            if (c >= 3) begin
                n_tests++;
                if ({ir, raddr_a, raddr_b, imm16} !== {instr, instr[11:8], instr[3:0], {{8{instr[7]}}, instr[7:0]}}) begin
                    n_fail++;
                    $display("FAIL decode instr=%h c=%0d got ir=%h ra=%h rb=%h imm=%h", instr, c, ir, raddr_a, raddr_b, imm16);
                end
            end
            if (c == 4 && k == K_ALU) begin
                n_tests++;
                if ({alu_op, alu_b_imm, wb_sel} !== {exp_op, instr[15:12] != 4'h0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL alu_ctl instr=%h got op=%h imm=%b wb=%b exp op=%h", instr, alu_op, alu_b_imm, wb_sel, exp_op);
                end
            end
            if (c == 4 && k == K_STOR) begin
                n_tests++;
                if (mem_wdata !== ra) begin
                    n_fail++;
                    $display("FAIL mem_wdata instr=%h got %h exp %h", instr, mem_wdata, ra);
                end
            end
            if (c == 6) begin
                n_tests++;
                if (wb_sel !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wb_sel_load instr=%h got %b exp 1", instr, wb_sel);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        exp_pc = exp_pc + 16'd1;
        n_tests++;
        if (state_dbg !== 3'd0 || pc !== exp_pc) begin
            n_fail++;
            $display("FAIL end instr=%h got state=%0d pc=%h exp state=0 pc=%h", instr, state_dbg, pc, exp_pc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;
        #1;
        n_tests++;
        if ({pc, ir, state_dbg, mem_addr, reg_enable, mem_we, wb_sel, alu_op, alu_b_imm} !==
            {16'h0000, 16'h0000, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got pc=%h ir=%h st=%0d addr=%h en=%h we=%b wb=%b op=%h imm=%b",
                     pc, ir, state_dbg, mem_addr, reg_enable, mem_we, wb_sel, alu_op, alu_b_imm);
        end
        n_tests++;
        if (w_pc !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_preset got %h exp ffff", w_pc);
        end
        exp_pc = 16'h0000;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_instr(16'h0312, 16'h1111, 16'h2222);   // R-type
        run_instr(16'h52F0, 16'h0000, 16'h0000);   // immediate, negative imm
        run_instr(16'h4106, 16'h0000, 16'h0040);   // LOAD
        run_instr(16'h4347, 16'hBEEF, 16'h0080);   // STOR
        run_instr(16'h0F10, 16'h0001, 16'h0002);   // R-type writing the status register
        run_instr(16'h1F05, 16'h0001, 16'h0002);   // immediate writing the status register
        run_instr(16'h4F02, 16'h0000, 16'h0033);   // LOAD into the status register
        run_instr(16'hE123, 16'h0000, 16'h0000);   // reserved opcode
        run_instr(16'h4290, 16'h0000, 16'h0000);   // opcode 4 with an undefined sub-opcode
    endtask

    task automatic test_run_hold();
        run = 1'b0;
        repeat (8) begin
            n_tests++;
            if (state_dbg !== 3'd0 || mem_addr !== exp_pc || pc !== exp_pc) begin
                n_fail++;
                $display("FAIL hold got st=%0d addr=%h pc=%h exp pc %h", state_dbg, mem_addr, pc, exp_pc);
            end
            @(posedge clk);
            @(negedge clk);
        end
        // Dropping run after the instruction starts lets it complete, and then the FSM holds.
        mem[exp_pc[7:0]] = 16'h0512;
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        exp_pc = exp_pc + 16'd1;
        repeat (4) begin
            n_tests++;
            if (state_dbg !== 3'd0 || pc !== exp_pc) begin
                n_fail++;
                $display("FAIL run_drop got st=%0d pc=%h exp st=0 pc=%h", state_dbg, pc, exp_pc);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [15:0] instr;
        for (int n = 0; n < 40; n++) begin
            instr = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                instr[15:12] = 4'h4;
                instr[7:4]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h4;
            end
            run_instr(instr, 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic test_reset_in_lwb();
        mem[exp_pc[7:0]] = 16'h4106;
        rdata_b = 16'h0040;
        run     = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_tests++;
        if (state_dbg !== 3'd5) begin
            n_fail++;
            $display("FAIL reach_lwb got %0d exp 5", state_dbg);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (reg_enable !== 16'h0000 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pulse got en=%h we=%b exp 0", reg_enable, mem_we);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (pc !== 16'h0000 || state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_state got pc=%h st=%0d exp pc=0 st=0", pc, state_dbg);
        end
        reset  = 1'b0;
        run    = 1'b0;
        exp_pc = 16'h0000;
    endtask

    task automatic test_pc_wrap();
        n_tests++;
        if (w_pc !== 16'hFFFF || w_state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_start got pc=%h st=%0d exp ffff/0", w_pc, w_state_dbg);
        end
        run_w = 1'b1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        run_w = 1'b0;
        n_tests++;
        if (w_pc !== 16'h0000 || w_state_dbg !== 3'd0 || w_reg_enable !== 16'h0000) begin
            n_fail++;
            $display("FAIL pc_wrap got pc=%h st=%0d exp pc=0000 st=0", w_pc, w_state_dbg);
        end
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        run_w       = 1'b0;
        rdata_a     = '0;
        rdata_b     = '0;
        w_mem_rdata = 16'hE000;
        exp_pc      = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
        @(negedge clk);
        test_reset();
        test_directed();
        test_run_hold();
        test_random();
        test_reset_in_lwb();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
